// File: rtl/xgmii_rx_mac_if.sv
// xgmii_rx_mac_if: XGMII receive words in, payload word stream out.
//   xgmii_data/xgmii_ctrl/xgmii_valid : XGMII lanes, per-lane control flags, word qualifier
//   data/data_keep/data_valid/data_err : payload word, byte keep, word strobe, bad-frame flag
//   master: the receive MAC; slave: the PCS/consumer side
interface xgmii_rx_mac_if #(
  parameter int XGMII_DATA_WIDTH = 32,
  parameter int XGMII_CTRL_WIDTH = XGMII_DATA_WIDTH/8,
  parameter int O_DATA_WIDTH = 32,
  parameter int O_DATA_KEEP_WIDTH = O_DATA_WIDTH/8
);
  logic [XGMII_DATA_WIDTH-1:0] xgmii_data;
  logic [XGMII_CTRL_WIDTH-1:0] xgmii_ctrl;
  logic xgmii_valid;
  logic [O_DATA_WIDTH-1:0] data;
  logic [O_DATA_KEEP_WIDTH-1:0] data_keep;
  logic data_valid;
  logic data_err;
  modport master (input xgmii_data, xgmii_ctrl, xgmii_valid, output data, data_keep, data_valid, data_err);
  modport slave (output xgmii_data, xgmii_ctrl, xgmii_valid, input data, data_keep, data_valid, data_err);
endinterface

// File: rtl/xgmii_rx_mac.sv
// xgmii_rx_mac: 10G receive MAC; strips preamble/FCS, checks CRC-32 and runt length.
//   i_clk     : single clock, rising edge
//   i_reset_n : asynchronous active-low reset
//   bus       : xgmii_rx_mac_if master (XGMII in, keep-qualified payload out)
module xgmii_rx_mac #(
  parameter int XGMII_DATA_WIDTH = 32,
  parameter int XGMII_CTRL_WIDTH = XGMII_DATA_WIDTH/8,
  parameter int O_DATA_WIDTH = 32,
  parameter int O_DATA_KEEP_WIDTH = O_DATA_WIDTH/8
) (
  input logic i_clk,
  input logic i_reset_n,
  xgmii_rx_mac_if.master bus
);
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;
  state_t state, state_n;
  logic [XGMII_DATA_WIDTH-1:0] a, a_n, b, b_n;
  logic a_vld, a_vld_n, b_vld, b_vld_n;
  // B is still owed to the output after the frame ended
  logic flush, flush_n;
  logic [O_DATA_KEEP_WIDTH-1:0] fkeep, fkeep_n;
  logic ferr, ferr_n;
  logic [31:0] crc, crc_n, crc_w;
  logic [15:0] cnt, cnt_n;
  logic [O_DATA_WIDTH-1:0] od, od_n;
  logic [O_DATA_KEEP_WIDTH-1:0] ok, ok_n;
  logic ov, ov_n, oe, oe_n;
  logic [2:0] k;
  logic [7:0] lb;
  logic [16:0] tot;
  logic term, bad, start;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

  // k = lowest control lane (4 when none); CRC runs over the data lanes below it
  always_comb begin
    k = 3'd4;
    lb = 8'h00;
    for (int i = XGMII_CTRL_WIDTH - 1; i >= 0; i--)
      if (bus.xgmii_ctrl[i]) begin
        k = 3'(i);
        lb = bus.xgmii_data[8*i +: 8];
      end
    crc_w = crc;
    for (int i = 0; i < XGMII_CTRL_WIDTH; i++)
      if (i < int'(k)) crc_w = crc_byte(crc_w, bus.xgmii_data[8*i +: 8]);
  end

  // tot counts bytes after the SFD including FCS, so a runt is tot < 64
  assign tot = {1'b0, cnt} + 17'(k);
  assign term = lb == 8'hFD;
  assign bad = crc_w != 32'hDEBB20E3 || tot < 17'd64;
  assign start = bus.xgmii_ctrl == XGMII_CTRL_WIDTH'(1) && bus.xgmii_data[7:0] == 8'hFB;

  always_comb begin
    state_n = state;
    a_n = a;
    b_n = b;
    a_vld_n = a_vld;
    b_vld_n = b_vld;
    flush_n = flush;
    fkeep_n = fkeep;
    ferr_n = ferr;
    crc_n = crc;
    cnt_n = cnt;
    od_n = od;
    ok_n = ok;
    ov_n = 1'b0;
    oe_n = oe;
    if (bus.xgmii_valid) begin
      ok_n = '0;
      oe_n = 1'b0;
      flush_n = 1'b0;
      if (flush) begin
        od_n = b;
        ok_n = fkeep;
        ov_n = 1'b1;
        oe_n = ferr;
      end
      case (state)
        IDLE: state_n = start ? PREAMBLE : IDLE;
        PREAMBLE: begin
          state_n = bus.xgmii_ctrl == '0 && bus.xgmii_data == 32'hD5555555 ? DATA : IDLE;
          a_vld_n = 1'b0;
          b_vld_n = 1'b0;
          crc_n = '1;
          cnt_n = '0;
        end
        DATA: begin
          if (bus.xgmii_ctrl == '0) begin
            crc_n = crc_w;
            cnt_n = tot[16] ? 16'hFFFF : tot[15:0];
            a_n = b;
            b_n = bus.xgmii_data;
            a_vld_n = b_vld;
            b_vld_n = 1'b1;
            if (a_vld) begin
              od_n = a;
              ok_n = '1;
              ov_n = 1'b1;
            end
          end else begin
            state_n = IDLE;
            a_vld_n = 1'b0;
            b_vld_n = 1'b0;
            if (term) begin
              // k==0: B is all FCS so A is last; otherwise B carries the tail bytes
              if (a_vld) begin
                od_n = a;
                ok_n = '1;
                ov_n = 1'b1;
                oe_n = k == 3'd0 && bad;
              end
              flush_n = b_vld && k != 3'd0;
              fkeep_n = O_DATA_KEEP_WIDTH'((5'd1 << k) - 5'd1);
              ferr_n = bad;
            end else if (a_vld) begin
              od_n = a;
              ok_n = '1;
              ov_n = 1'b1;
              flush_n = 1'b1;
              fkeep_n = '1;
              ferr_n = 1'b1;
            end else if (b_vld) begin
              od_n = b;
              ok_n = '1;
              ov_n = 1'b1;
              oe_n = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      a_vld <= 1'b0;
      b_vld <= 1'b0;
      flush <= 1'b0;
      fkeep <= '0;
      ferr <= 1'b0;
      crc <= '1;
      cnt <= '0;
      od <= '0;
      ok <= '0;
      ov <= 1'b0;
      oe <= 1'b0;
    end else begin
      state <= state_n;
      a <= a_n;
      b <= b_n;
      a_vld <= a_vld_n;
      b_vld <= b_vld_n;
      flush <= flush_n;
      fkeep <= fkeep_n;
      ferr <= ferr_n;
      crc <= crc_n;
      cnt <= cnt_n;
      od <= od_n;
      ok <= ok_n;
      ov <= ov_n;
      oe <= oe_n;
    end

  assign bus.data = od;
  assign bus.data_keep = ok;
  assign bus.data_valid = ov;
  assign bus.data_err = oe;
endmodule

// File: tb/tb_xgmii_rx_mac.sv
// tb_xgmii_rx_mac: directed frames against a byte-level frame model of xgmii_rx_mac.
module tb_xgmii_rx_mac;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  xgmii_rx_mac_if bus ();
  xgmii_rx_mac dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));

  typedef struct packed {logic [31:0] d; logic [3:0] k; logic e;} ow_t;
  ow_t exq[$];
  logic [7:0] pl[$];
  logic [7:0] fr[$];
  int n_chk, n_pass, n_out, n_exp, o0;
  logic [3:0] last_keep;
  logic last_err;
  logic [3:0] kt [4] = '{4'h1, 4'h3, 4'h7, 4'hF};

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic put(input logic [31:0] d, input logic [3:0] c, input logic v);
    ow_t w;
    logic [31:0] m;
    bus.xgmii_data = d;
    bus.xgmii_ctrl = c;
    bus.xgmii_valid = v;
    @(posedge clk);
    #1;
    if (!v) check("valid low", 64'(bus.data_valid), 64'd0);
    if (bus.data_valid) begin
      n_out++;
      last_keep = bus.data_keep;
      last_err = bus.data_err;
      if (exq.size() != 0) begin
        w = exq.pop_front();
        m = {{8{w.k[3]}}, {8{w.k[2]}}, {8{w.k[1]}}, {8{w.k[0]}}};
        check("data", 64'(bus.data & m), 64'(w.d & m));
        check("keep", 64'(bus.data_keep), 64'(w.k));
        check("err", 64'(bus.data_err), 64'(w.e));
      end
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] c, input bit tog);
    if (tog) put($urandom, 4'($urandom), 1'b0);
    put(d, c, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) put(32'h07070707, 4'hF, 1'b1);
  endtask

  // Sends pl as a frame with FCS; stop_at>=0 cuts the frame after that many data words
  task automatic send(input bit flip, input bit bad_pre, input bit tog, input int stop_at, input bit abrt, input int gap);
    logic [31:0] c, w;
    int n, k, p, nw;
    ow_t o;
    p = pl.size();
    fr = pl;
    c = '1;
    foreach (pl[i]) c = crc_byte(c, pl[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
    if (flip) fr[p] = fr[p] ^ 8'h01;
    n = fr.size();
    if (!bad_pre) begin
      nw = stop_at >= 0 ? stop_at : (p + 3) / 4;
      for (int i = 0; i < nw; i++) begin
        for (int j = 0; j < 4; j++) o.d[8*j +: 8] = (4*i + j < n) ? fr[4*i + j] : 8'h00;
        o.k = (stop_at >= 0 || 4*i + 4 <= p) ? 4'hF : 4'((1 << (p - 4*i)) - 1);
        o.e = i == nw - 1 && (stop_at >= 0 || flip || p < 60);
        exq.push_back(o);
        n_exp++;
      end
    end
    drive(32'h555555FB, 4'b0001, tog);
    drive(bad_pre ? 32'hD5555554 : 32'hD5555555, 4'h0, tog);
    for (int i = 0; i < n/4; i++) begin
      if (i == stop_at) begin
        if (abrt) begin
          drive(32'h070707FE, 4'hF, tog);
          idle(gap);
        end
        return;
      end
      drive({fr[4*i+3], fr[4*i+2], fr[4*i+1], fr[4*i]}, 4'h0, tog);
    end
    k = n % 4;
    w = 32'h07070707;
    for (int j = 0; j < 4; j++)
      if (j < k) w[8*j +: 8] = fr[4*(n/4) + j];
      else if (j == k) w[8*j +: 8] = 8'hFD;
    drive(w, 4'(4'hF << k), tog);
    idle(gap);
  endtask

  task automatic ramp(input int len);
    pl.delete();
    for (int i = 0; i < len; i++) pl.push_back(8'(i));
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    n_out = 0;
    n_exp = 0;
    bus.xgmii_data = 32'h07070707;
    bus.xgmii_ctrl = 4'hF;
    bus.xgmii_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset data", 64'(bus.data), 64'd0);
    check("reset keep", 64'(bus.data_keep), 64'd0);
    check("reset valid", 64'(bus.data_valid), 64'd0);
    check("reset err", 64'(bus.data_err), 64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    ramp(60);
    o0 = n_out;
    send(0, 0, 0, -1, 0, 3);
    check("60B words", 64'(n_out - o0), 64'd15);
    check("60B last keep", 64'(last_keep), 64'hF);
    check("60B last err", 64'(last_err), 64'd0);

    for (int l = 61; l <= 64; l++) begin
      ramp(l);
      send(0, 0, 0, -1, 0, 3);
      check("tail keep", 64'(last_keep), 64'(kt[l-61]));
      check("tail err", 64'(last_err), 64'd0);
    end

    pl.delete();
    for (int i = 0; i < 10; i++) pl.push_back(8'hA0 + 8'(i));
    while (pl.size() < 60) pl.push_back(8'h00);
    o0 = n_out;
    send(0, 0, 0, -1, 0, 3);
    check("padded words", 64'(n_out - o0), 64'd15);
    check("padded err", 64'(last_err), 64'd0);

    ramp(60);
    send(1, 0, 0, -1, 0, 3);
    check("bad fcs err", 64'(last_err), 64'd1);

    ramp(40);
    o0 = n_out;
    send(0, 0, 0, -1, 0, 3);
    check("runt words", 64'(n_out - o0), 64'd10);
    check("runt err", 64'(last_err), 64'd1);

    ramp(60);
    o0 = n_out;
    send(0, 1, 0, -1, 0, 3);
    check("bad preamble words", 64'(n_out - o0), 64'd0);

    ramp(64);
    o0 = n_out;
    send(0, 0, 0, 5, 1, 3);
    check("abort words", 64'(n_out - o0), 64'd5);
    check("abort err", 64'(last_err), 64'd1);

    o0 = n_out;
    ramp(61);
    send(0, 0, 0, -1, 0, 0);
    ramp(63);
    send(0, 0, 0, -1, 0, 3);
    check("back-to-back words", 64'(n_out - o0), 64'd32);

    for (int f = 0; f < 100; f++) begin
      pl.delete();
      repeat ($urandom_range(0, 100)) pl.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 1) while (pl.size() < 60) pl.push_back(8'h00);
      send($urandom_range(0, 7) == 0, 0, 1, -1, 0, $urandom_range(0, 2));
    end
    idle(3);
    check("toggle total words", 64'(n_out), 64'(n_exp));

    ramp(64);
    send(0, 0, 0, 8, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midreset data", 64'(bus.data), 64'd0);
    check("midreset keep", 64'(bus.data_keep), 64'd0);
    check("midreset valid", 64'(bus.data_valid), 64'd0);
    check("midreset err", 64'(bus.data_err), 64'd0);
    n_exp = n_exp - exq.size();
    exq.delete();
    idle(2);
    rst_n = 1'b1;
    idle(1);
    ramp(62);
    o0 = n_out;
    send(0, 0, 0, -1, 0, 3);
    check("post-reset words", 64'(n_out - o0), 64'd16);
    check("post-reset keep", 64'(last_keep), 64'h3);
    check("post-reset err", 64'(last_err), 64'd0);

    check("total words", 64'(n_out), 64'(n_exp));
    check("leftover", 64'(exq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
